mdu_sched: RTL and testbench

Issue scheduler and writeback arbiter for the multiply/divide unit in the idex stage. It buffers M-extension ops from decode in a small FIFO and issues them one at a time to the MDU as single-cycle start pulses. It arbitrates the single register-file write port between the ALU pipeline (priority) and MDU results. It also raises a RAW-hazard stall for any source register that matches a pending MDU destination.

---
 rtl/mdu_sched.sv | 197 +++++++++++++++++++
 tb/tb_mdu_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: issue scheduler and register-file writeback arbiter for the
// multiply/divide unit. Decode ops are buffered in a small FIFO and issued
// one at a time. The ALU always owns the write port when it asks for it, and
// an MDU result that loses arbitration is parked until the port frees up.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no op in flight; issues the FIFO head when one is available
// WAIT  | op issued, waiting for mdu_finish
// HOLD  | result captured, waiting for the ALU to release the write port
// DROP  | flushed while in flight; the next mdu_finish is swallowed
module mdu_sched #(
    parameter int DEPTH    = 2,
    parameter int XLEN     = 32,
    parameter int REG_SIZE = 5,
    parameter int INFO_W   = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [INFO_W-1:0]            req_info,
    input  logic [XLEN-1:0]              req_rs1,
    input  logic [XLEN-1:0]              req_rs2,
    input  logic [REG_SIZE-1:0]          req_rd,
    output logic                         mdu_start,
    output logic [INFO_W-1:0]            mdu_info,
    output logic [XLEN-1:0]              mdu_rs1,
    output logic [XLEN-1:0]              mdu_rs2,
    output logic [REG_SIZE-1:0]          mdu_rd,
    input  logic                         mdu_finish,
    input  logic [XLEN-1:0]              mdu_result,
    input  logic                         alu_wb_valid,
    input  logic [REG_SIZE-1:0]          alu_wb_rd,
    input  logic [XLEN-1:0]              alu_wb_data,
    output logic                         rf_we,
    output logic [REG_SIZE-1:0]          rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    input  logic [REG_SIZE-1:0]          hz_rs1,
    input  logic [REG_SIZE-1:0]          hz_rs2,
    output logic                         hz_stall,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t               state;
    logic [REG_SIZE-1:0]  cur_rd;
    logic [XLEN-1:0]      hold_data;

    logic [INFO_W-1:0]    q_info [DEPTH];
    logic [XLEN-1:0]      q_rs1  [DEPTH];
    logic [XLEN-1:0]      q_rs2  [DEPTH];
    logic [REG_SIZE-1:0]  q_rd   [DEPTH];
    logic [DEPTH-1:0]     q_vld;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic push;
    logic issue;
    logic mdu_wr;

    // A pop never frees a slot for a same-cycle push, so readiness depends on
    // the registered occupancy alone.
    assign req_ready = (count != FULL_CNT) & ~flush;
    assign push      = req_valid & req_ready;
    assign issue     = (state == S_IDLE) & (count != '0) & ~flush;
    assign q_count   = count;

    assign mdu_start = issue;
    assign mdu_info  = issue ? q_info[rd_ptr] : '0;
    assign mdu_rs1   = issue ? q_rs1[rd_ptr]  : '0;
    assign mdu_rs2   = issue ? q_rs2[rd_ptr]  : '0;
    assign mdu_rd    = issue ? q_rd[rd_ptr]   : '0;

    assign mdu_wr = ~flush & ~alu_wb_valid &
                    (((state == S_WAIT) & mdu_finish) | (state == S_HOLD));

    // FIFO pointers, occupancy and per-entry valid flags (valid feeds hazard)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else begin
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (issue) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(issue);
        end
    end

    // FIFO payload storage; contents are qualified by q_vld so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_info[wr_ptr] <= req_info;
            q_rs1[wr_ptr]  <= req_rs1;
            q_rs2[wr_ptr]  <= req_rs2;
            q_rd[wr_ptr]   <= req_rd;
        end
    end

    // Issue / completion / writeback sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_rd    <= '0;
            hold_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        cur_rd <= q_rd[rd_ptr];
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= mdu_finish ? S_IDLE : S_DROP;
                    end else if (mdu_finish) begin
                        if (alu_wb_valid) begin
                            hold_data <= mdu_result;
                            state     <= S_HOLD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush || !alu_wb_valid) state <= S_IDLE;
                end
                S_DROP: begin
                    if (mdu_finish) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-port mux: ALU first; x0 writes are suppressed but still consume
    // the MDU slot. Address/data read as zero whenever no write happens.
    always_comb begin
        logic                sel_v;
        logic [REG_SIZE-1:0] sel_rd;
        logic [XLEN-1:0]     sel_data;
        sel_v    = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        if (alu_wb_valid) begin
            sel_v    = 1'b1;
            sel_rd   = alu_wb_rd;
            sel_data = alu_wb_data;
        end else if (mdu_wr) begin
            sel_v    = 1'b1;
            sel_rd   = cur_rd;
            sel_data = (state == S_HOLD) ? hold_data : mdu_result;
        end
        rf_we    = sel_v & (sel_rd != '0);
        rf_waddr = rf_we ? sel_rd : '0;
        rf_wdata = rf_we ? sel_data : '0;
    end

    // RAW hazard against queued entries and the op in flight (not DROP)
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_rd[i] == hz_rs1)) hit1 = 1'b1;
            if (q_vld[i] && (q_rd[i] == hz_rs2)) hit2 = 1'b1;
        end
        if ((state == S_WAIT) || (state == S_HOLD)) begin
            if (cur_rd == hz_rs1) hit1 = 1'b1;
            if (cur_rd == hz_rs2) hit2 = 1'b1;
        end
        hz_stall = (hit1 & (hz_rs1 != '0)) | (hit2 & (hz_rs2 != '0));
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: a cycle-by-cycle vector table for the basic
// issue/writeback/hold/x0 flows, then hand-written fill, flush and reset runs.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_info;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        mdu_start;
    logic [11:0] mdu_info;
    logic [31:0] mdu_rs1, mdu_rs2;
    logic [4:0]  mdu_rd;
    logic        mdu_finish;
    logic [31:0] mdu_result;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  hz_rs1, hz_rs2;
    logic        hz_stall;
    logic [1:0]  q_count;

    int n_chk  = 0;
    int n_pass = 0;

    mdu_sched dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_info(req_info),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .mdu_start(mdu_start), .mdu_info(mdu_info), .mdu_rs1(mdu_rs1),
        .mdu_rs2(mdu_rs2), .mdu_rd(mdu_rd),
        .mdu_finish(mdu_finish), .mdu_result(mdu_result),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_stall(hz_stall), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [11:0] info;
        logic [31:0] rs1, rs2;
        logic [4:0]  rd;
        logic        fin;
        logic [31:0] res;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic [4:0]  h1, h2;
        logic        e_rr, e_st;
        logic [11:0] e_info;
        logic [31:0] e_rs1, e_rs2;
        logic [4:0]  e_rd;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_hz;
        logic [1:0]  e_qc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        input logic rv, input logic [11:0] info, input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [4:0] rd, input logic fin, input logic [31:0] res,
        input logic av, input logic [4:0] ard, input logic [31:0] adata,
        input logic [4:0] h1, input logic [4:0] h2,
        input logic e_rr, input logic e_st, input logic [11:0] e_info,
        input logic [31:0] e_rs1, input logic [31:0] e_rs2, input logic [4:0] e_rd,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_hz, input logic [1:0] e_qc);
        vec_t v;
        v.rv = rv; v.info = info; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.fin = fin; v.res = res; v.av = av; v.ard = ard; v.adata = adata;
        v.h1 = h1; v.h2 = h2;
        v.e_rr = e_rr; v.e_st = e_st; v.e_info = e_info; v.e_rs1 = e_rs1;
        v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_we = e_we; v.e_wa = e_wa;
        v.e_wd = e_wd; v.e_hz = e_hz; v.e_qc = e_qc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic idle_in();
        flush = 0; req_valid = 0; req_info = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        mdu_finish = 0; mdu_result = '0; alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
        hz_rs1 = '0; hz_rs2 = '0;
    endtask

    task automatic push(input logic [11:0] info, input logic [4:0] rd);
        req_valid = 1; req_info = info; req_rs1 = 32'd1; req_rs2 = 32'd2; req_rd = rd;
    endtask

    task automatic sample();
        #4;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_op(input logic [4:0] rd, input logic [31:0] res, input string tag);
        idle_in();
        mdu_finish = 1; mdu_result = res;
        sample();
        chk({tag, " we"}, 32'(rf_we), 32'(rd != 0));
        chk({tag, " waddr"}, 32'(rf_waddr), 32'(rd));
        nxt();
        idle_in();
    endtask

    localparam logic [11:0] MUL  = 12'h010;
    localparam logic [11:0] MULH = 12'h020;
    localparam logic [11:0] MHSU = 12'h040;
    localparam logic [11:0] DIV  = 12'h100;

    initial begin
        //           rv info rs1 rs2 rd fin res      av ard adata h1 h2 | rr st info  rs1 rs2 rd we wa wd       hz qc
        vecs[0]  = mk(1, MUL, 3, 4, 5, 0, 0,        0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[1]  = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 5,   1, 1, MUL,  3, 4, 5,  0, 0, 0,        1, 1);
        vecs[2]  = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 5,   1, 0, 0,    0, 0, 0,  0, 0, 0,        1, 0);
        vecs[3]  = mk(0, 0,   0, 0, 0, 1, 12,       0, 0, 0,    0, 5,   1, 0, 0,    0, 0, 0,  1, 5, 12,       1, 0);
        vecs[4]  = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 5,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[5]  = mk(1, MUL, 2, 2, 6, 0, 0,        0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[6]  = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 0,   1, 1, MUL,  2, 2, 6,  0, 0, 0,        0, 1);
        vecs[7]  = mk(0, 0,   0, 0, 0, 1, 32'h1234, 1, 7, 8'hAA, 0, 0,  1, 0, 0,    0, 0, 0,  1, 7, 32'hAA,   0, 0);
        vecs[8]  = mk(0, 0,   0, 0, 0, 0, 0,        1, 7, 8'hAA, 6, 0,  1, 0, 0,    0, 0, 0,  1, 7, 32'hAA,   1, 0);
        vecs[9]  = mk(0, 0,   0, 0, 0, 0, 0,        1, 7, 8'hAA, 0, 0,  1, 0, 0,    0, 0, 0,  1, 7, 32'hAA,   0, 0);
        vecs[10] = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  1, 6, 32'h1234, 0, 0);
        vecs[11] = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    6, 0,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[12] = mk(1, MULH,1, 1, 0, 0, 0,        0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[13] = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 0,   1, 1, MULH, 1, 1, 0,  0, 0, 0,        0, 1);
        vecs[14] = mk(0, 0,   0, 0, 0, 1, 32'h55,   0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[15] = mk(1, MHSU,0, 0, 3, 0, 0,        0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  0, 0, 0,        0, 0);
        vecs[16] = mk(0, 0,   0, 0, 0, 0, 0,        0, 0, 0,    0, 0,   1, 1, MHSU, 0, 0, 3,  0, 0, 0,        0, 1);
        vecs[17] = mk(0, 0,   0, 0, 0, 1, 7,        0, 0, 0,    0, 0,   1, 0, 0,    0, 0, 0,  1, 3, 7,        0, 0);

        // reset state
        idle_in();
        rst_n = 0;
        #12;
        chk("rst req_ready", 32'(req_ready), 1);
        chk("rst q_count", 32'(q_count), 0);
        chk("rst mdu_start", 32'(mdu_start), 0);
        chk("rst rf_we", 32'(rf_we), 0);
        chk("rst hz_stall", 32'(hz_stall), 0);
        chk("rst mdu_info", 32'(mdu_info), 0);
        chk("rst rf_waddr", 32'(rf_waddr), 0);
        chk("rst rf_wdata", rf_wdata, 0);
        nxt();
        rst_n = 1;
        nxt();

        // vector table: one row per clock cycle
        for (int i = 0; i < 18; i++) begin
            idle_in();
            req_valid = vecs[i].rv; req_info = vecs[i].info; req_rs1 = vecs[i].rs1;
            req_rs2 = vecs[i].rs2; req_rd = vecs[i].rd;
            mdu_finish = vecs[i].fin; mdu_result = vecs[i].res;
            alu_wb_valid = vecs[i].av; alu_wb_rd = vecs[i].ard; alu_wb_data = vecs[i].adata;
            hz_rs1 = vecs[i].h1; hz_rs2 = vecs[i].h2;
            sample();
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rr));
            chk($sformatf("row%0d mdu_start", i), 32'(mdu_start), 32'(vecs[i].e_st));
            chk($sformatf("row%0d mdu_info", i), 32'(mdu_info), 32'(vecs[i].e_info));
            chk($sformatf("row%0d mdu_rs1", i), mdu_rs1, vecs[i].e_rs1);
            chk($sformatf("row%0d mdu_rs2", i), mdu_rs2, vecs[i].e_rs2);
            chk($sformatf("row%0d mdu_rd", i), 32'(mdu_rd), 32'(vecs[i].e_rd));
            chk($sformatf("row%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            chk($sformatf("row%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_wa));
            chk($sformatf("row%0d rf_wdata", i), rf_wdata, vecs[i].e_wd);
            chk($sformatf("row%0d hz_stall", i), 32'(hz_stall), 32'(vecs[i].e_hz));
            chk($sformatf("row%0d q_count", i), 32'(q_count), 32'(vecs[i].e_qc));
            nxt();
        end
        idle_in();

        // fill past DEPTH while an op is in flight; ordering and no pass-through
        push(DIV, 5'd10); nxt();
        idle_in(); sample();
        chk("fill start a", 32'(mdu_start), 1);
        chk("fill rd a", 32'(mdu_rd), 10);
        nxt();
        push(MUL, 5'd11); sample();
        chk("fill ready b", 32'(req_ready), 1);
        nxt();
        push(MUL, 5'd12); sample();
        chk("fill ready c", 32'(req_ready), 1);
        chk("fill qc c", 32'(q_count), 1);
        nxt();
        push(MUL, 5'd13); hz_rs1 = 5'd12; hz_rs2 = 5'd14; sample();
        chk("fill ready full", 32'(req_ready), 0);
        chk("fill qc full", 32'(q_count), 2);
        chk("fill no start in wait", 32'(mdu_start), 0);
        chk("fill hz queued", 32'(hz_stall), 1);
        nxt();
        hz_rs1 = '0; hz_rs2 = '0;
        mdu_finish = 1; mdu_result = 32'd99; sample();
        chk("fill wb a we", 32'(rf_we), 1);
        chk("fill wb a addr", 32'(rf_waddr), 10);
        chk("fill ready while full", 32'(req_ready), 0);
        nxt();
        mdu_finish = 0; mdu_result = '0; sample();
        chk("fill start b", 32'(mdu_start), 1);
        chk("fill rd b", 32'(mdu_rd), 11);
        chk("fill no passthru", 32'(req_ready), 0);
        nxt();
        sample();
        chk("fill ready after pop", 32'(req_ready), 1);
        chk("fill qc after pop", 32'(q_count), 1);
        nxt();
        finish_op(5'd11, 32'd1, "fill wb b");
        sample();
        chk("fill start c", 32'(mdu_start), 1);
        chk("fill rd c", 32'(mdu_rd), 12);
        nxt();
        finish_op(5'd12, 32'd2, "fill wb c");
        sample();
        chk("fill start d", 32'(mdu_start), 1);
        chk("fill rd d", 32'(mdu_rd), 13);
        nxt();
        finish_op(5'd13, 32'd3, "fill wb d");
        sample();
        chk("fill qc empty", 32'(q_count), 0);
        nxt();

        // flush with DIV in flight and two queued
        push(DIV, 5'd20); nxt();
        push(MUL, 5'd21); sample();
        chk("fl start", 32'(mdu_start), 1);
        nxt();
        push(MUL, 5'd22); nxt();
        idle_in(); flush = 1; sample();
        chk("fl ready", 32'(req_ready), 0);
        chk("fl no issue", 32'(mdu_start), 0);
        nxt();
        idle_in(); hz_rs1 = 5'd20; hz_rs2 = 5'd21; sample();
        chk("fl qc", 32'(q_count), 0);
        chk("fl drop no stall", 32'(hz_stall), 0);
        chk("fl no start", 32'(mdu_start), 0);
        nxt();
        idle_in(); mdu_finish = 1; mdu_result = 32'hDEAD; sample();
        chk("fl dropped we", 32'(rf_we), 0);
        nxt();
        idle_in(); push(MUL, 5'd23); nxt();
        idle_in(); sample();
        chk("fl new start", 32'(mdu_start), 1);
        chk("fl new rd", 32'(mdu_rd), 23);
        nxt();
        finish_op(5'd23, 32'd5, "fl new wb");

        // flush coinciding with finish in WAIT: discard and return to IDLE
        push(MUL, 5'd27); nxt();
        idle_in(); nxt();
        flush = 1; mdu_finish = 1; mdu_result = 32'h33; sample();
        chk("flfin we", 32'(rf_we), 0);
        nxt();
        idle_in(); push(MUL, 5'd28); nxt();
        idle_in(); sample();
        chk("flfin idle start", 32'(mdu_start), 1);
        chk("flfin idle rd", 32'(mdu_rd), 28);
        nxt();
        finish_op(5'd28, 32'd6, "flfin wb");

        // reset while in flight: late finish is ignored
        push(MUL, 5'd25); nxt();
        idle_in(); nxt();
        hz_rs1 = 5'd25; sample();
        chk("rst mid hz before", 32'(hz_stall), 1);
        rst_n = 0; #1;
        chk("rst mid hz", 32'(hz_stall), 0);
        chk("rst mid qc", 32'(q_count), 0);
        nxt();
        rst_n = 1;
        idle_in(); mdu_finish = 1; mdu_result = 32'h77; sample();
        chk("rst mid late finish we", 32'(rf_we), 0);
        nxt();
        idle_in(); push(MUL, 5'd26); nxt();
        idle_in(); sample();
        chk("rst mid new start", 32'(mdu_start), 1);
        chk("rst mid new rd", 32'(mdu_rd), 26);
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
